// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter: fixed-priority owner arbitration of a shared VGA write port with idle timeout.
module vga_plot_arbiter #(
  parameter int N_REQ   = 5,
  parameter int XW      = 9,
  parameter int YW      = 8,
  parameter int CW      = 3,
  parameter int TIMEOUT = 1023
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   done,
  input  logic [N_REQ-1:0]   pix_valid,
  input  logic [N_REQ*XW-1:0] x_in,
  input  logic [N_REQ*YW-1:0] y_in,
  input  logic [N_REQ*CW-1:0] col_in,
  output logic [N_REQ-1:0]   grant,
  output logic [N_REQ-1:0]   ack,
  output logic               plot,
  output logic [XW-1:0]      x,
  output logic [YW-1:0]      y,
  output logic [CW-1:0]      colour,
  output logic               busy,
  output logic               timeout_err
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;
  state_t state, state_nx;
  logic [N_REQ-1:0] grant_nx, first;
  logic [TW-1:0] cnt, cnt_nx;
  logic [XW-1:0] sx;
  logic [YW-1:0] sy;
  logic [CW-1:0] sc;
  logic ready, acc, own_req, own_done, pre, tmo, rel, terr_nx;
  always_comb begin
    first = '0;
    sx = '0;
    sy = '0;
    sc = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        first = '0;
        first[i] = 1'b1;
      end
      if (grant[i]) begin
        sx = x_in[i*XW +: XW];
        sy = y_in[i*YW +: YW];
        sc = col_in[i*CW +: CW];
      end
    end
  end
  assign own_req  = |(grant & req);
  assign own_done = |(grant & done);
  assign pre      = req[0] & ~grant[0];
  assign acc      = (state == OWN) && |(grant & pix_valid) && !pre;
  assign ack      = acc ? (grant & pix_valid) : '0;
  assign tmo      = (state == OWN) && (cnt == TW'(TIMEOUT)) && !acc;
  assign rel      = own_done | ~own_req | pre | tmo;
  assign busy     = (state == OWN);
  always_comb begin
    state_nx = state;
    grant_nx = grant;
    cnt_nx   = cnt;
    terr_nx  = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (ready && |req) begin
          state_nx = OWN;
          grant_nx = first;
        end
      end
      OWN: begin
        cnt_nx = acc ? '0 : (cnt == TW'(TIMEOUT)) ? cnt : cnt + TW'(1);
        if (rel) begin
          state_nx = GAP;
          grant_nx = '0;
          // any concurrent normal release or preemption masks the timeout report
          terr_nx  = tmo & own_req & ~own_done & ~pre;
        end
      end
      GAP: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
      default: begin
        state_nx = IDLE;
        grant_nx = '0;
        cnt_nx   = '0;
      end
    endcase
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      grant       <= '0;
      cnt         <= '0;
      ready       <= 1'b0;
      timeout_err <= 1'b0;
      plot        <= 1'b0;
      x           <= XW'(1);
      y           <= '0;
      colour      <= '1;
    end else begin
      state       <= state_nx;
      grant       <= grant_nx;
      cnt         <= cnt_nx;
      ready       <= 1'b1;
      timeout_err <= terr_nx;
      plot        <= acc;
      x           <= acc ? sx : XW'(1);
      y           <= acc ? sy : '0;
      colour      <= acc ? sc : '1;
    end
  end
endmodule
